// File: rtl/fb_pkg.sv
// Shared constants, engine state encoding and palette-cell address table for the frame-buffer write scheduler.
// Latency: not applicable (package only).
// Backpressure: not applicable (package only).
package fb_pkg;

  localparam int ADDR_W   = 13;
  localparam int COL_W    = 2;
  localparam int BG_CELLS = 12;
  localparam int BG_VAL_W = 2 * BG_CELLS;

  localparam logic [ADDR_W-1:0] BG_BASE     = 13'h1FF3;
  localparam logic [3:0]        BG_LAST_IDX = 4'(BG_CELLS - 1);

  typedef enum logic [1:0] {
    ENG_IDLE   = 2'd0,
    ENG_CLEAR  = 2'd1,
    ENG_BGLOAD = 2'd2
  } eng_state_e;

  // Palette cell k of the background loader; 13'h1FFE is deliberately absent.
  function automatic logic [ADDR_W-1:0] bg_addr(input logic [3:0] idx);
    logic [ADDR_W-1:0] a;
    case (idx)
      4'd0:    a = 13'h1FFB;
      4'd1:    a = 13'h1FFC;
      4'd2:    a = 13'h1FFD;
      4'd3:    a = 13'h1FFF;
      4'd4:    a = 13'h1FF7;
      4'd5:    a = 13'h1FF8;
      4'd6:    a = 13'h1FF9;
      4'd7:    a = 13'h1FFA;
      4'd8:    a = 13'h1FF3;
      4'd9:    a = 13'h1FF4;
      4'd10:   a = 13'h1FF5;
      4'd11:   a = 13'h1FF6;
      default: a = BG_BASE;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/fb_write_sched_rr_arb2.sv
// Two-requester round-robin arbiter; requester 0 is the host, requester 1 the engine.
// Latency: combinational grant; only the last-grant pointer is registered.
// Backpressure: a loser simply sees no grant and keeps requesting.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  // 1 = requester 1 was granted last; reset value makes the host win the first tie.
  logic last_q;

  // Tie goes to whoever was not granted last; a sole requester always wins.
  always_comb begin
    gnt_o = req_i;
    if (req_i[0] && req_i[1]) begin
      gnt_o = last_q ? 2'b01 : 2'b10;
    end
  end

  // Remember which side took the port most recently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= 1'b1;
    end else if (gnt_o[0]) begin
      last_q <= 1'b0;
    end else if (gnt_o[1]) begin
      last_q <= 1'b1;
    end
  end

endmodule

// File: rtl/fb_write_sched.sv
// Frame-buffer write-port owner: round-robin between host pixel writes and the clear/background engine.
// Latency: grant in cycle N drives fb_* with fb_ie=0 (and host_ack) in cycle N+1, one write per cycle.
// Backpressure: host holds host_req until host_ack; engine waits for its grant. Macro FB_WR_BG_PROTECT_EN
// swallows host writes to palette cells (ack still given).
module fb_write_sched #(
  parameter int                ADDR_W     = 13,
  parameter int                COL_W      = 2,
  parameter logic [ADDR_W-1:0] CLEAR_LAST = 13'h1FF2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              host_req,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [COL_W-1:0]  host_colour,
  output logic              host_ack,
  input  logic              clr_start,
  input  logic [COL_W-1:0]  clr_colour,
  output logic              clr_busy,
  input  logic              bg_load,
  input  logic [23:0]       bg_value,
  output logic              bg_busy,
  output logic [ADDR_W-1:0] fb_address,
  output logic [COL_W-1:0]  fb_colour,
  output logic              fb_ie
);

  import fb_pkg::*;

  eng_state_e        state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic [3:0]        idx_q;
  logic [COL_W-1:0]  clr_col_q;
  logic [23:0]       bg_val_q;
  logic [23:0]       bg_next_q;
  logic              clr_pend_q;
  logic              bg_pend_q;
  logic              clr_tail_q;
  logic              bg_tail_q;
  logic              clr_busy_q;
  logic              bg_busy_q;
  logic              host_ack_q;
  logic              fb_ie_q;
  logic              fb_ie_d;
  logic [ADDR_W-1:0] fb_address_q;
  logic [ADDR_W-1:0] fb_address_d;
  logic [COL_W-1:0]  fb_colour_q;
  logic [COL_W-1:0]  fb_colour_d;

  logic [1:0] req;
  logic [1:0] gnt;
  logic       host_gnt;
  logic       eng_gnt;
  logic       clr_last;
  logic       bg_last;

  // The ack cycle masks the host so a still-held request is not written twice.
  assign req[0]   = host_req & ~host_ack_q;
  assign req[1]   = (state_q != ENG_IDLE);
  assign host_gnt = gnt[0];
  assign eng_gnt  = gnt[1];
  assign clr_last = (state_q == ENG_CLEAR)  && eng_gnt && (cnt_q == CLEAR_LAST);
  assign bg_last  = (state_q == ENG_BGLOAD) && eng_gnt && (idx_q == BG_LAST_IDX);

  rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .req_i (req),
    .gnt_o (gnt)
  );

  // Select what the granted side writes next cycle; idle leaves address/colour as they were.
  always_comb begin
    fb_ie_d      = 1'b1;
    fb_address_d = fb_address_q;
    fb_colour_d  = fb_colour_q;
    if (host_gnt) begin
`ifdef FB_WR_BG_PROTECT_EN
      if (host_addr < BG_BASE) begin
        fb_ie_d      = 1'b0;
        fb_address_d = host_addr;
        fb_colour_d  = host_colour;
      end
`else
      fb_ie_d      = 1'b0;
      fb_address_d = host_addr;
      fb_colour_d  = host_colour;
`endif
    end else if (eng_gnt) begin
      fb_ie_d = 1'b0;
      if (state_q == ENG_CLEAR) begin
        fb_address_d = cnt_q;
        fb_colour_d  = clr_col_q;
      end else begin
        fb_address_d = bg_addr(idx_q);
        fb_colour_d  = bg_val_q[{idx_q, 1'b0} +: COL_W];
      end
    end
  end

  // Registered write port and host acknowledge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fb_ie_q      <= 1'b1;
      fb_address_q <= '0;
      fb_colour_q  <= '0;
      host_ack_q   <= 1'b0;
    end else begin
      fb_ie_q      <= fb_ie_d;
      fb_address_q <= fb_address_d;
      fb_colour_q  <= fb_colour_d;
      host_ack_q   <= host_gnt;
    end
  end

  // Engine FSM with pending requests and busy flags; busy drops one cycle after the final write pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ENG_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      clr_col_q  <= '0;
      bg_val_q   <= '0;
      bg_next_q  <= '0;
      clr_pend_q <= 1'b0;
      bg_pend_q  <= 1'b0;
      clr_tail_q <= 1'b0;
      bg_tail_q  <= 1'b0;
      clr_busy_q <= 1'b0;
      bg_busy_q  <= 1'b0;
    end else begin
      clr_tail_q <= clr_last;
      bg_tail_q  <= bg_last;
      if (clr_tail_q && (state_q != ENG_CLEAR) && !clr_pend_q) clr_busy_q <= 1'b0;
      if (bg_tail_q && (state_q != ENG_BGLOAD) && !bg_pend_q) bg_busy_q <= 1'b0;

      case (state_q)
        ENG_IDLE: begin
          if (clr_start) begin
            state_q    <= ENG_CLEAR;
            cnt_q      <= '0;
            clr_col_q  <= clr_colour;
            clr_busy_q <= 1'b1;
            if (bg_load) begin
              bg_pend_q <= 1'b1;
              bg_next_q <= bg_value;
              bg_busy_q <= 1'b1;
            end
          end else if (bg_load) begin
            state_q   <= ENG_BGLOAD;
            idx_q     <= '0;
            bg_val_q  <= bg_value;
            bg_busy_q <= 1'b1;
          end
        end

        ENG_CLEAR: begin
          if (bg_load) begin
            bg_pend_q <= 1'b1;
            bg_next_q <= bg_value;
            bg_busy_q <= 1'b1;
          end
          if (eng_gnt) begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CLEAR_LAST) begin
              if (bg_pend_q || bg_load) begin
                state_q   <= ENG_BGLOAD;
                idx_q     <= '0;
                bg_val_q  <= bg_load ? bg_value : bg_next_q;
                bg_pend_q <= 1'b0;
              end else begin
                state_q <= ENG_IDLE;
              end
            end
          end
        end

        ENG_BGLOAD: begin
          if (clr_start) begin
            clr_pend_q <= 1'b1;
            clr_col_q  <= clr_colour;
            clr_busy_q <= 1'b1;
          end
          if (bg_load) begin
            bg_pend_q <= 1'b1;
            bg_next_q <= bg_value;
            bg_busy_q <= 1'b1;
          end
          if (eng_gnt) begin
            idx_q <= idx_q + 4'd1;
            if (idx_q == BG_LAST_IDX) begin
              if (clr_pend_q || clr_start) begin
                state_q    <= ENG_CLEAR;
                cnt_q      <= '0;
                clr_pend_q <= 1'b0;
              end else if (bg_pend_q || bg_load) begin
                idx_q     <= '0;
                bg_val_q  <= bg_load ? bg_value : bg_next_q;
                bg_pend_q <= 1'b0;
              end else begin
                state_q <= ENG_IDLE;
              end
            end
          end
        end

        default: state_q <= ENG_IDLE;
      endcase
    end
  end

  assign host_ack   = host_ack_q;
  assign clr_busy   = clr_busy_q;
  assign bg_busy    = bg_busy_q;
  assign fb_ie      = fb_ie_q;
  assign fb_address = fb_address_q;
  assign fb_colour  = fb_colour_q;

endmodule

// File: tb/tb_fb_write_sched.sv
// Directed self-checking bench for fb_write_sched, built with CLEAR_LAST = 13'h000F.
// Inputs change and outputs are sampled on the falling clock edge.
// Honours FB_WR_BG_PROTECT_EN for the palette-protection scenario.
module tb_fb_write_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        host_req;
  logic [12:0] host_addr;
  logic [1:0]  host_colour;
  logic        host_ack;
  logic        clr_start;
  logic [1:0]  clr_colour;
  logic        clr_busy;
  logic        bg_load;
  logic [23:0] bg_value;
  logic        bg_busy;
  logic [12:0] fb_address;
  logic [1:0]  fb_colour;
  logic        fb_ie;

  int n_checks = 0;
  int n_fail   = 0;

  logic [12:0] bg_a [12] = '{13'h1FFB, 13'h1FFC, 13'h1FFD, 13'h1FFF,
                             13'h1FF7, 13'h1FF8, 13'h1FF9, 13'h1FFA,
                             13'h1FF3, 13'h1FF4, 13'h1FF5, 13'h1FF6};
  // 24'h000093 hand-decoded per cell.
  logic [1:0]  bg_c93 [12] = '{2'd3, 2'd0, 2'd1, 2'd2, 2'd0, 2'd0,
                               2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};

  always #5 clk = ~clk;

  fb_write_sched #(.CLEAR_LAST(13'h000F)) dut (
    .clk         (clk),
    .rst         (rst),
    .host_req    (host_req),
    .host_addr   (host_addr),
    .host_colour (host_colour),
    .host_ack    (host_ack),
    .clr_start   (clr_start),
    .clr_colour  (clr_colour),
    .clr_busy    (clr_busy),
    .bg_load     (bg_load),
    .bg_value    (bg_value),
    .bg_busy     (bg_busy),
    .fb_address  (fb_address),
    .fb_colour   (fb_colour),
    .fb_ie       (fb_ie)
  );

  task automatic test_reset();
    rst = 1'b1; host_req = 1'b0; host_addr = '0; host_colour = '0;
    clr_start = 1'b0; clr_colour = '0; bg_load = 1'b0; bg_value = '0;
    repeat (2) @(negedge clk);
    n_checks++; if (fb_ie !== 1'b1) begin n_fail++; $display("FAIL reset_fb_ie: got %b expected 1", fb_ie); end
    n_checks++; if (fb_address !== 13'h0) begin n_fail++; $display("FAIL reset_fb_address: got %h expected 0", fb_address); end
    n_checks++; if (fb_colour !== 2'd0) begin n_fail++; $display("FAIL reset_fb_colour: got %0d expected 0", fb_colour); end
    n_checks++; if (host_ack !== 1'b0) begin n_fail++; $display("FAIL reset_host_ack: got %b expected 0", host_ack); end
    n_checks++; if (clr_busy !== 1'b0) begin n_fail++; $display("FAIL reset_clr_busy: got %b expected 0", clr_busy); end
    n_checks++; if (bg_busy !== 1'b0) begin n_fail++; $display("FAIL reset_bg_busy: got %b expected 0", bg_busy); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (fb_ie !== 1'b1) begin n_fail++; $display("FAIL idle_fb_ie: got %b expected 1", fb_ie); end
  endtask

  task automatic test_bg_load();
    bg_load = 1'b1; bg_value = 24'h000093;
    @(negedge clk);
    bg_load = 1'b0; bg_value = 24'hFFFFFF;
    n_checks++; if (bg_busy !== 1'b1) begin n_fail++; $display("FAIL bg_busy_rise: got %b expected 1", bg_busy); end
    n_checks++; if (fb_ie !== 1'b1) begin n_fail++; $display("FAIL bg_first_gap: got fb_ie %b expected 1", fb_ie); end
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      n_checks++;
      if (fb_ie !== 1'b0 || fb_address !== bg_a[k] || fb_colour !== bg_c93[k] || bg_busy !== 1'b1) begin
        n_fail++;
        $display("FAIL bg_write[%0d]: got ie=%b addr=%h col=%0d busy=%b expected ie=0 addr=%h col=%0d busy=1",
                 k, fb_ie, fb_address, fb_colour, bg_busy, bg_a[k], bg_c93[k]);
      end
    end
    @(negedge clk);
    n_checks++; if (fb_ie !== 1'b1 || bg_busy !== 1'b0) begin
      n_fail++; $display("FAIL bg_end: got ie=%b busy=%b expected ie=1 busy=0", fb_ie, bg_busy);
    end
  endtask

  task automatic test_clear();
    clr_start = 1'b1; clr_colour = 2'd2;
    @(negedge clk);
    clr_start = 1'b0; clr_colour = 2'd0;
    n_checks++; if (clr_busy !== 1'b1) begin n_fail++; $display("FAIL clr_busy_rise: got %b expected 1", clr_busy); end
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      n_checks++;
      if (fb_ie !== 1'b0 || fb_address !== 13'(k) || fb_colour !== 2'd2 || clr_busy !== 1'b1) begin
        n_fail++;
        $display("FAIL clr_write[%0d]: got ie=%b addr=%h col=%0d busy=%b expected ie=0 addr=%h col=2 busy=1",
                 k, fb_ie, fb_address, fb_colour, clr_busy, 13'(k));
      end
    end
    @(negedge clk);
    n_checks++; if (fb_ie !== 1'b1 || clr_busy !== 1'b0) begin
      n_fail++; $display("FAIL clr_end: got ie=%b busy=%b expected ie=1 busy=0", fb_ie, clr_busy);
    end
  endtask

  task automatic test_host_vs_clear();
    logic [12:0] rec_addr [64];
    logic [1:0]  rec_col  [64];
    int          rec_cyc  [64];
    int          nwr = 0;
    int          nack = 0;
    int          nh = 0;
    int          nc = 0;
    bit          seq_ok = 1'b1;
    clr_start = 1'b1; clr_colour = 2'd1;
    host_req = 1'b1; host_addr = 13'h0100; host_colour = 2'd3;
    fork
      begin
        for (int i = 0; i < 3; i++) begin
          int t;
          host_addr = 13'h0100 + 13'(i);
          t = 0;
          do begin @(negedge clk); t++; end while (host_ack !== 1'b1 && t < 40);
          n_checks++;
          if (host_ack !== 1'b1) begin n_fail++; $display("FAIL host_ack_timeout[%0d]: got %b expected 1", i, host_ack); end
        end
        host_req = 1'b0;
      end
      begin
        for (int c = 0; c < 40; c++) begin
          @(negedge clk);
          if (c == 0) clr_start = 1'b0;
          if (host_ack === 1'b1) nack++;
          if (fb_ie === 1'b0 && nwr < 64) begin
            rec_addr[nwr] = fb_address; rec_col[nwr] = fb_colour; rec_cyc[nwr] = c; nwr++;
          end
        end
      end
    join
    n_checks++; if (nwr != 19) begin n_fail++; $display("FAIL mix_write_count: got %0d expected 19", nwr); end
    n_checks++; if (nack != 3) begin n_fail++; $display("FAIL mix_ack_count: got %0d expected 3", nack); end
    for (int j = 0; j < nwr; j++) begin
      if (rec_cyc[j] != rec_cyc[0] + j) seq_ok = 1'b0;
      if (rec_col[j] == 2'd3) begin
        if (rec_addr[j] != 13'h0100 + 13'(nh)) seq_ok = 1'b0;
        if (j > 0 && rec_col[j-1] == 2'd3) seq_ok = 1'b0;
        nh++;
      end else begin
        if (rec_addr[j] != 13'(nc) || rec_col[j] != 2'd1) seq_ok = 1'b0;
        nc++;
      end
    end
    n_checks++; if (nh != 3 || nc != 16) begin n_fail++; $display("FAIL mix_split: got host=%0d clear=%0d expected host=3 clear=16", nh, nc); end
    n_checks++; if (!seq_ok) begin n_fail++; $display("FAIL mix_order: got out-of-order/gapped/duplicate writes expected alternating consecutive writes"); end
    n_checks++; if (clr_busy !== 1'b0) begin n_fail++; $display("FAIL mix_clr_busy_end: got %b expected 0", clr_busy); end
  endtask

  task automatic test_clear_then_bg();
    logic [23:0] v = 24'hC6_1B_E4;
    clr_start = 1'b1; clr_colour = 2'd2; bg_load = 1'b1; bg_value = v;
    @(negedge clk);
    clr_start = 1'b0; bg_load = 1'b0; bg_value = '0;
    n_checks++; if (clr_busy !== 1'b1 || bg_busy !== 1'b1) begin
      n_fail++; $display("FAIL both_busy_rise: got clr=%b bg=%b expected 1 1", clr_busy, bg_busy);
    end
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      n_checks++;
      if (fb_ie !== 1'b0 || fb_address !== 13'(k) || fb_colour !== 2'd2 || clr_busy !== 1'b1 || bg_busy !== 1'b1) begin
        n_fail++;
        $display("FAIL both_clr[%0d]: got ie=%b addr=%h col=%0d clr=%b bg=%b expected ie=0 addr=%h col=2 clr=1 bg=1",
                 k, fb_ie, fb_address, fb_colour, clr_busy, bg_busy, 13'(k));
      end
    end
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      n_checks++;
      if (fb_ie !== 1'b0 || fb_address !== bg_a[k] || fb_colour !== v[2*k +: 2] || clr_busy !== 1'b0 || bg_busy !== 1'b1) begin
        n_fail++;
        $display("FAIL both_bg[%0d]: got ie=%b addr=%h col=%0d clr=%b bg=%b expected ie=0 addr=%h col=%0d clr=0 bg=1",
                 k, fb_ie, fb_address, fb_colour, clr_busy, bg_busy, bg_a[k], v[2*k +: 2]);
      end
    end
    @(negedge clk);
    n_checks++; if (fb_ie !== 1'b1 || bg_busy !== 1'b0) begin
      n_fail++; $display("FAIL both_end: got ie=%b bg=%b expected ie=1 bg=0", fb_ie, bg_busy);
    end
  endtask

  task automatic test_protect();
    host_req = 1'b1; host_addr = 13'h1FF5; host_colour = 2'd1;
    @(negedge clk);
    host_req = 1'b0;
    n_checks++; if (host_ack !== 1'b1) begin n_fail++; $display("FAIL prot_ack: got %b expected 1", host_ack); end
`ifdef FB_WR_BG_PROTECT_EN
    n_checks++; if (fb_ie !== 1'b1) begin n_fail++; $display("FAIL prot_ie: got %b expected 1", fb_ie); end
`else
    n_checks++; if (fb_ie !== 1'b0 || fb_address !== 13'h1FF5 || fb_colour !== 2'd1) begin
      n_fail++; $display("FAIL prot_write: got ie=%b addr=%h col=%0d expected ie=0 addr=1ff5 col=1", fb_ie, fb_address, fb_colour);
    end
`endif
    @(negedge clk);
    n_checks++; if (host_ack !== 1'b0 || fb_ie !== 1'b1) begin
      n_fail++; $display("FAIL prot_single: got ack=%b ie=%b expected ack=0 ie=1", host_ack, fb_ie);
    end
  endtask

  task automatic test_reset_mid_clear();
    int nw = 0;
    clr_start = 1'b1; clr_colour = 2'd3;
    @(negedge clk);
    clr_start = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++; if (fb_ie !== 1'b0) begin n_fail++; $display("FAIL midclr_running: got ie=%b expected 0", fb_ie); end
    rst = 1'b1;
    #1;
    n_checks++; if (fb_ie !== 1'b1 || clr_busy !== 1'b0) begin
      n_fail++; $display("FAIL midclr_reset: got ie=%b busy=%b expected ie=1 busy=0", fb_ie, clr_busy);
    end
    @(negedge clk);
    n_checks++; if (fb_ie !== 1'b1 || clr_busy !== 1'b0) begin
      n_fail++; $display("FAIL midclr_reset_next: got ie=%b busy=%b expected ie=1 busy=0", fb_ie, clr_busy);
    end
    rst = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (fb_ie === 1'b0) nw++;
    end
    n_checks++; if (nw != 0 || clr_busy !== 1'b0) begin
      n_fail++; $display("FAIL midclr_no_resume: got writes=%0d busy=%b expected writes=0 busy=0", nw, clr_busy);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_bg_load();
    test_clear();
    test_host_vs_clear();
    test_clear_then_bg();
    test_protect();
    test_reset_mid_clear();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
